// File: rtl/glyph_serializer.sv
// Serializes one row of a fixed-size glyph into a pixel stream, with horizontal scale and trailing gap.
// Optional build macro GLYPH_INVERT_EN enables the req_char[7] foreground-invert flag.
module glyph_serializer #(
  parameter int unsigned GLYPH_W  = 5,
  parameter int unsigned GLYPH_H  = 7,
  parameter int unsigned CHAR_MIN = 32,
  parameter int unsigned CHAR_MAX = 127,
  parameter int unsigned SCALE    = 1,
  parameter int unsigned GAP      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 req_char,
  input  logic [2:0]                 req_row,
  input  logic                       flush,
  output logic [6:0]                 rom_addr,
  input  logic [GLYPH_W*GLYPH_H-1:0] rom_data,
  output logic                       pix_valid,
  output logic                       pix_out
);

  localparam int unsigned PIXC  = GLYPH_W * SCALE;
  localparam int unsigned TOTAL = PIXC + GAP;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned RW    = $clog2(SCALE + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               pix_q, pix_d;
  logic [6:0]         addr_q, addr_d;
  logic [2:0]         row_q, row_d;
  logic [GLYPH_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      rep_q, rep_d;
  logic               inv;
  logic               accept;
  logic [6:0]         code_mapped;
  logic [GLYPH_W-1:0] slice;

`ifdef GLYPH_INVERT_EN
  logic inv_q, inv_d;
  assign inv = inv_q;
`else
  logic unused_invert_bit;
  assign unused_invert_bit = req_char[7];
  assign inv = 1'b0;
`endif

  assign req_ready = ready_q & ~flush;
  assign accept    = req_valid & req_ready;
  assign rom_addr  = addr_q;
  assign pix_valid = valid_q;
  assign pix_out   = pix_q;

  always_comb begin
    code_mapped = req_char[6:0];
    if (32'(req_char[6:0]) < CHAR_MIN || 32'(req_char[6:0]) > CHAR_MAX)
      code_mapped = 7'(CHAR_MAX);
  end

  // Rows at or beyond GLYPH_H select nothing and leave the slice blank.
  always_comb begin
    slice = '0;
    for (int unsigned r = 0; r < GLYPH_H; r++)
      if (32'(row_q) == r) slice = rom_data[r*GLYPH_W +: GLYPH_W];
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    row_d   = row_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
`ifdef GLYPH_INVERT_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = code_mapped;
          row_d   = req_row;
`ifdef GLYPH_INVERT_EN
          inv_d   = req_char[7];
`endif
          state_d = FETCH;
        end
      end
      FETCH: begin
        shreg_d = slice;
        cnt_d   = '0;
        rep_d   = '0;
        valid_d = 1'b1;
        pix_d   = slice[GLYPH_W-1] ^ inv;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CW'(TOTAL - 1)) begin
          valid_d = 1'b0;
          pix_d   = 1'b0;
          cnt_d   = '0;
          rep_d   = '0;
          shreg_d = '0;
          state_d = IDLE;
          if (accept) begin
            addr_d  = code_mapped;
            row_d   = req_row;
`ifdef GLYPH_INVERT_EN
            inv_d   = req_char[7];
`endif
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (rep_q == RW'(SCALE - 1)) begin
            rep_d   = '0;
            shreg_d = shreg_q << 1;
          end else begin
            rep_d = rep_q + RW'(1);
          end
          // Pixels are registered one cycle ahead; gap cycles never invert.
          pix_d = shreg_d[GLYPH_W-1] ^ (inv & (32'(cnt_d) < PIXC));
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      pix_d   = 1'b0;
      cnt_d   = '0;
      rep_d   = '0;
      shreg_d = '0;
    end
    ready_d = (state_d == IDLE) || (state_d == SHIFT && cnt_d == CW'(TOTAL - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      pix_q   <= 1'b0;
      addr_q  <= 7'(CHAR_MAX);
      row_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
`ifdef GLYPH_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
`ifdef GLYPH_INVERT_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule

// File: doc/glyph_serializer.md
GLYPH_SERIALIZER -- requirements
Module: glyph_serializer

Interface
REQ-001 SHALL have parameter GLYPH_W, default 5, glyph width in pixels.
REQ-002 SHALL have parameter GLYPH_H, default 7, glyph height in rows.
REQ-003 SHALL have parameter CHAR_MIN, default 32, lowest valid character code.
REQ-004 SHALL have parameter CHAR_MAX, default 127, highest valid code; also the substitute code.
REQ-005 SHALL have parameter SCALE, default 1 (range 1..4), horizontal repeat per pixel.
REQ-006 SHALL have parameter GAP, default 1 (range 0..3), blank pixels after each glyph.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port req_valid, input, 1, glyph-row request present.
REQ-010 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-011 SHALL have port req_char, input, 8, character code ([7] is the invert flag, see Configuration).
REQ-012 SHALL have port req_row, input, 3, glyph row index.
REQ-013 SHALL have port flush, input, 1, synchronous abort to IDLE.
REQ-014 SHALL have port rom_addr, output, 7, code presented to an external combinational glyph ROM.
REQ-015 SHALL have port rom_data, input, GLYPH_W*GLYPH_H, glyph bitmap; pixel (r,c) = rom_data[r*GLYPH_W + GLYPH_W-1-c].
REQ-016 SHALL have port pix_valid, output, 1, pix_out is meaningful this cycle.
REQ-017 SHALL have port pix_out, output, 1, serialized pixel (1 = foreground).

Function
REQ-018 SHALL implement FSM IDLE -> FETCH -> SHIFT -> (IDLE or FETCH).
REQ-019 SHALL assert req_ready in IDLE and on the final SHIFT cycle only.
REQ-020 SHALL, on acceptance, register code and row, then enter FETCH.
REQ-021 SHALL map codes outside CHAR_MIN..CHAR_MAX (using req_char[6:0]) to CHAR_MAX before driving rom_addr.
REQ-022 SHALL, in FETCH, latch the GLYPH_W-bit row slice of rom_data into a shift register; if row >= GLYPH_H, latch all zeros.
REQ-023 SHALL, in SHIFT, hold pix_valid=1 for exactly GLYPH_W*SCALE+GAP cycles.
REQ-024 SHALL output pixel c (leftmost first) for SCALE consecutive cycles each, then GAP cycles of 0.
REQ-025 SHALL make the first pix_valid appear 2 cycles after the acceptance edge.
REQ-026 SHALL, on a request accepted in the final SHIFT cycle, go to FETCH (one pix_valid=0 bubble), else to IDLE.
REQ-027 SHALL, with flush=1, enter IDLE next cycle with pix_valid=0 and discard the held request; flush overrides a simultaneous acceptance (req_ready forced 0 while flush=1).
REQ-028 SHALL drive pix_out=0 whenever pix_valid=0.

Reset
REQ-029 SHALL, on rst, asynchronously set state IDLE, pix_valid=0, pix_out=0, rom_addr=CHAR_MAX, shift register and counters 0; req_ready=1 after release.
REQ-030 SHALL abort any in-progress glyph on rst with no further pix_valid until a new request.

Configuration
REQ-031 SHALL honour macro GLYPH_INVERT_EN: when defined, req_char[7]=1 inverts foreground pixels (gap pixels stay 0); when undefined, req_char[7] is ignored and no invert storage exists.

Verification
REQ-032 SHALL cover: ROM stub row2 of code 0x41 = 5'b10001, SCALE=1, GAP=1, request (0x41,2) -> pix_valid 6 cycles, pix_out 1,0,0,0,1,0, first valid 2 cycles after accept.
REQ-033 SHALL cover: SCALE=2 same request -> 11 valid cycles, pix_out 1,1,0,0,0,0,0,0,1,1,0.
REQ-034 SHALL cover: code 0x10 -> rom_addr=127; row 7 -> six zero pixels.
REQ-035 SHALL cover: back-to-back requests held on req_valid -> exactly one bubble cycle between glyphs; flush mid-SHIFT -> pix_valid=0 next cycle, req_ready=1 following cycle.
REQ-036 SHALL cover: rst asserted mid-SHIFT -> pix_valid and pix_out 0 immediately (before next edge).
REQ-037 SHALL cover (GLYPH_INVERT_EN defined): request 0xC1 row2 -> pix_out 0,1,1,1,0,0.
